// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first.
// Subtraction is performed as A + ~B + ~Cin, so Cout=1 in subtract mode means
// "no borrow". The result, Cout and Ovf are only updated on the final chunk,
// so the outputs never show partial sums.
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched operands (B already conditioned for subtract) and working sum
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Architecturally visible result registers
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Chunk datapath
    logic [N-1:0]     chunk_hit;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] work_merged;
    logic             last_chunk;
    logic             msb_carry_in;

    // One-hot decode of the chunk currently being processed
    for (genvar gi = 0; gi < N; gi++) begin : g_hit
        assign chunk_hit[gi] = (idx_q == IDX_W'(gi));
    end

    assign last_chunk = (idx_q == IDX_W'(N - 1));

    // Select the active operand chunk, add it, and merge the sum into the working word
    always_comb begin
        a_chunk     = '0;
        b_chunk     = '0;
        work_merged = work_q;
        for (int i = 0; i < N; i++) begin
            if (chunk_hit[i]) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        for (int i = 0; i < N; i++) begin
            if (chunk_hit[i]) begin
                work_merged[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            end
        end
    end

    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB can be recovered from the MSB sum bit
    assign msb_carry_in = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ work_merged[WIDTH-1];

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub ^ Cin;
                    work_d  = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d  = work_merged;
                carry_d = chunk_sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (last_chunk) begin
                    s_d     = work_merged;
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = msb_carry_in ^ chunk_sum[CHUNK];
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: directed cases on a 16/4 instance plus
// randomized back-to-back operations on four configurations run in parallel,
// all checked against an arithmetic reference model.
module tb_seq_addsub;

    localparam int NRAND = 2500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total    = 0;
    int bad      = 0;
    int rand_fin = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic void ref_model(input int w, input logic op_sub,
                                      input longint unsigned a, input longint unsigned b,
                                      input logic cin,
                                      output longint unsigned s, output logic co, output logic ov);
        longint unsigned modv;
        longint half, sa, sb, r;
        modv = 64'd1 << w;
        half = longint'(modv >> 1);
        sa   = (longint'(a) >= half) ? longint'(a) - longint'(modv) : longint'(a);
        sb   = (longint'(b) >= half) ? longint'(b) - longint'(modv) : longint'(b);
        if (!op_sub) begin
            s  = (a + b + 64'(cin)) & (modv - 1);
            co = ((a + b + 64'(cin)) >= modv);
            r  = sa + sb + longint'(cin);
        end else begin
            s  = (a - b - 64'(cin)) & (modv - 1);
            co = (a >= b + 64'(cin));
            r  = sa - sb - longint'(cin);
        end
        ov = (r >= half) || (r < -half);
    endfunction

    // ---------------- directed instance: WIDTH=16, CHUNK=4 ----------------
    logic        d_rst, d_start, d_sub, d_cin;
    logic [15:0] d_a, d_b, d_s;
    logic        d_cout, d_ovf, d_busy, d_done;
    logic        rst_r;

    seq_addsub #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk  (clk),
        .rst  (d_rst),
        .start(d_start),
        .sub  (d_sub),
        .A    (d_a),
        .B    (d_b),
        .Cin  (d_cin),
        .S    (d_s),
        .Cout (d_cout),
        .Ovf  (d_ovf),
        .busy (d_busy),
        .done (d_done)
    );

    // Issue one operation and watch 12 cycles; optional disturbance and mid-run reset
    task automatic d_op(input string name, input logic op_sub, input logic [15:0] a, input logic [15:0] b,
                        input logic op_cin, input bit disturb, input int rst_at,
                        output logic [15:0] s_o, output logic c_o, output logic v_o,
                        output int lat, output int pulses);
        d_start = 1'b1;
        d_sub   = op_sub;
        d_a     = a;
        d_b     = b;
        d_cin   = op_cin;
        @(negedge clk);
        d_start = 1'b0;
        lat     = -1;
        pulses  = 0;
        s_o     = d_s;
        c_o     = d_cout;
        v_o     = d_ovf;
        for (int c = 0; c < 12; c++) begin
            if (rst_at < 0 && c < 4) check_eq({name, "_busy"}, 64'(d_busy), 64'(1));
            if (d_done) begin
                pulses++;
                if (lat < 0) begin
                    lat = c;
                    s_o = d_s;
                    c_o = d_cout;
                    v_o = d_ovf;
                end
            end
            if (rst_at >= 0 && c == rst_at + 1) begin
                check_eq({name, "_rst_busy"}, 64'(d_busy), 64'(0));
                check_eq({name, "_rst_done"}, 64'(d_done), 64'(0));
                check_eq({name, "_rst_s"}, 64'(d_s), 64'(0));
                check_eq({name, "_rst_cout"}, 64'(d_cout), 64'(0));
            end
            d_rst   = (c == rst_at);
            d_start = disturb && (c == 1 || c == 4);
            if (disturb && c < 4) begin
                d_a   = 16'($urandom);
                d_b   = 16'($urandom);
                d_sub = 1'($urandom);
                d_cin = 1'($urandom);
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            s_o = d_s;
            c_o = d_cout;
            v_o = d_ovf;
        end
        $display("dir %s sub=%b a=%h b=%h cin=%b -> s=%h cout=%b ovf=%b lat=%0d pulses=%0d",
                 name, op_sub, a, b, op_cin, s_o, c_o, v_o, lat, pulses);
    endtask

    initial begin
        logic [15:0] s;
        logic        co, ov;
        int          lat, pulses;

        d_rst = 1'b1; rst_r = 1'b1;
        d_start = 1'b1; d_sub = 1'b0; d_a = 16'h5a5a; d_b = 16'h0f0f; d_cin = 1'b1;
        repeat (3) @(negedge clk);
        // Reset held together with start: reset must win
        check_eq("rst_busy", 64'(d_busy), 64'(0));
        check_eq("rst_done", 64'(d_done), 64'(0));
        check_eq("rst_s", 64'(d_s), 64'(0));
        check_eq("rst_cout", 64'(d_cout), 64'(0));
        check_eq("rst_ovf", 64'(d_ovf), 64'(0));
        d_start = 1'b0; d_rst = 1'b0; rst_r = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", 64'(d_busy), 64'(0));

        d_op("wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, -1, s, co, ov, lat, pulses);
        check_eq("wrap_s", 64'(s), 64'(16'h0000));
        check_eq("wrap_cout", 64'(co), 64'(1));
        check_eq("wrap_ovf", 64'(ov), 64'(0));
        check_eq("wrap_lat", 64'(lat), 64'(4));
        check_eq("wrap_pulses", 64'(pulses), 64'(1));

        d_op("posovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, -1, s, co, ov, lat, pulses);
        check_eq("posovf_s", 64'(s), 64'(16'h8000));
        check_eq("posovf_cout", 64'(co), 64'(0));
        check_eq("posovf_ovf", 64'(ov), 64'(1));

        d_op("negovf", 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0, -1, s, co, ov, lat, pulses);
        check_eq("negovf_s", 64'(s), 64'(16'h0000));
        check_eq("negovf_cout", 64'(co), 64'(1));
        check_eq("negovf_ovf", 64'(ov), 64'(1));

        d_op("sub57", 1'b1, 16'h0005, 16'h0007, 1'b0, 1'b0, -1, s, co, ov, lat, pulses);
        check_eq("sub57_s", 64'(s), 64'(16'hFFFE));
        check_eq("sub57_cout", 64'(co), 64'(0));
        check_eq("sub57_ovf", 64'(ov), 64'(0));

        d_op("sub75", 1'b1, 16'h0007, 16'h0005, 1'b1, 1'b0, -1, s, co, ov, lat, pulses);
        check_eq("sub75_s", 64'(s), 64'(16'h0001));
        check_eq("sub75_cout", 64'(co), 64'(1));

        d_op("disturb", 1'b0, 16'h1234, 16'h4321, 1'b0, 1'b1, -1, s, co, ov, lat, pulses);
        check_eq("disturb_s", 64'(s), 64'(16'h5555));
        check_eq("disturb_cout", 64'(co), 64'(0));
        check_eq("disturb_lat", 64'(lat), 64'(4));
        check_eq("disturb_pulses", 64'(pulses), 64'(1));

        d_op("abort", 1'b0, 16'hAAAA, 16'h1111, 1'b0, 1'b0, 1, s, co, ov, lat, pulses);
        check_eq("abort_pulses", 64'(pulses), 64'(0));
        check_eq("abort_s", 64'(s), 64'(0));

        d_op("after", 1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0, -1, s, co, ov, lat, pulses);
        check_eq("after_s", 64'(s), 64'(16'h2345));
        check_eq("after_cout", 64'(co), 64'(0));
        check_eq("after_lat", 64'(lat), 64'(4));
        check_eq("after_pulses", 64'(pulses), 64'(1));

        for (int t = 0; t < 60000 && rand_fin < 4; t++) @(negedge clk);
        check_eq("rand_all_done", 64'(rand_fin), 64'(4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- randomized instances, one per configuration ----------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_rand
        localparam int W  = (gi == 2) ? 8 : (gi == 3) ? 32 : 16;
        localparam int C  = (gi == 0) ? 4 : (gi == 1) ? 16 : (gi == 2) ? 1 : 8;
        localparam int NC = W / C;

        logic         r_start, r_sub, r_cin;
        logic [W-1:0] r_a, r_b, r_s;
        logic         r_cout, r_ovf, r_busy, r_done;

        seq_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk  (clk),
            .rst  (rst_r),
            .start(r_start),
            .sub  (r_sub),
            .A    (r_a),
            .B    (r_b),
            .Cin  (r_cin),
            .S    (r_s),
            .Cout (r_cout),
            .Ovf  (r_ovf),
            .busy (r_busy),
            .done (r_done)
        );

        initial begin
            logic [W-1:0]    ea, eb;
            logic            es, ec;
            longint unsigned xs;
            logic            xc, xv;
            int              lat;

            r_start = 1'b0; r_sub = 1'b0; r_cin = 1'b0; r_a = '0; r_b = '0;
            @(negedge clk);
            for (int t = 0; t < 100 && rst_r; t++) @(negedge clk);
            for (int n = 0; n < NRAND; n++) begin
                ea = W'($urandom);
                eb = W'($urandom);
                es = 1'($urandom);
                ec = 1'($urandom);
                r_start = 1'b1; r_a = ea; r_b = eb; r_sub = es; r_cin = ec;
                @(negedge clk);
                lat = 0;
                // Scramble inputs and fire ignored starts while the operation runs
                while (!r_done && lat < NC + 3) begin
                    r_start = 1'($urandom);
                    r_a     = W'($urandom);
                    r_b     = W'($urandom);
                    r_sub   = 1'($urandom);
                    r_cin   = 1'($urandom);
                    @(negedge clk);
                    lat++;
                end
                ref_model(W, es, 64'(ea), 64'(eb), ec, xs, xc, xv);
                check_eq($sformatf("r%0d_s", gi), 64'(r_s), xs);
                check_eq($sformatf("r%0d_cout", gi), 64'(r_cout), 64'(xc));
                check_eq($sformatf("r%0d_ovf", gi), 64'(r_ovf), 64'(xv));
                check_eq($sformatf("r%0d_lat", gi), 64'(lat), 64'(NC));
                $display("rand cfg%0d #%0d sub=%b a=%h b=%h cin=%b -> s=%h cout=%b ovf=%b lat=%0d",
                         gi, n, es, ea, eb, ec, r_s, r_cout, r_ovf, lat);
                r_start = 1'b0;
                @(negedge clk);
            end
            rand_fin++;
        end
    end

endmodule
